// File: rtl/cam_row_scheduler.sv
// Camera row scheduler: keeps a 3-row sliding window of the frame and hands one
// window per interior row to the PE array, with a one-row skid for back-pressure.
module cam_row_scheduler #(
  parameter int ROW_W = 208,
  parameter int ROWS  = 34,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  input  logic             pe_ready,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_top,
  output logic [ROW_W-1:0] win_mid,
  output logic [ROW_W-1:0] win_bot,
  output logic [IDX_W-1:0] win_idx,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 2);
  localparam logic [IDX_W:0]   ROWS_L   = (IDX_W+1)'(ROWS);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
  logic [ROW_W-1:0]   skid_q, skid_d;
  logic               skid_full_q, skid_full_d;
  logic [IDX_W-1:0]   rows_in_q, rows_in_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic               win_valid_q, win_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;

  logic               shift;
  logic [ROW_W-1:0]   shift_src;
  logic               room;

  // Rows held (shifted in plus skid) must stay below ROWS for a new row to count;
  // anything beyond that belongs to no window and is silently discarded.
  assign room = ({1'b0, rows_in_q} + (IDX_W+1)'(skid_full_q)) < ROWS_L;

  always_comb begin
    state_d      = state_q;
    skid_d       = skid_q;
    skid_full_d  = skid_full_q;
    win_idx_d    = win_idx_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    shift        = 1'b0;
    shift_src    = row_data;

    if (sof) begin
      state_d     = FILL;
      skid_full_d = 1'b0;
      win_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (row_valid) begin
            shift = 1'b1;
            if (rows_in_q == IDX_W'(2)) begin
              state_d     = RUN;
              win_valid_d = 1'b1;
              win_idx_d   = IDX_W'(1);
            end
          end
        end
        RUN: begin
          if (frame_done_q) begin
            state_d = IDLE;
          end else if (win_valid_q) begin
            if (pe_ready) begin
              win_valid_d = 1'b0;
              if (win_idx_q == LAST_IDX) begin
                frame_done_d = 1'b1;
              end else if (row_valid && room) begin
                // A queued skid row is older, so a new row cannot overtake it.
                if (!skid_full_q) begin
                  shift       = 1'b1;
                  win_valid_d = 1'b1;
                  win_idx_d   = win_idx_q + 1'b1;
                end else begin
                  overflow_d = 1'b1;
                end
              end
            end else if (row_valid && room) begin
              if (!skid_full_q) begin
                skid_d      = row_data;
                skid_full_d = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
          end else if (skid_full_q) begin
            shift       = 1'b1;
            shift_src   = skid_q;
            skid_full_d = 1'b0;
            win_valid_d = 1'b1;
            win_idx_d   = win_idx_q + 1'b1;
            if (row_valid && room) begin
              skid_d      = row_data;
              skid_full_d = 1'b1;
            end
          end else if (row_valid && room) begin
            shift       = 1'b1;
            win_valid_d = 1'b1;
            win_idx_d   = win_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    s0_d      = shift ? s1_q : s0_q;
    s1_d      = shift ? s2_q : s1_q;
    s2_d      = shift ? shift_src : s2_q;
    rows_in_d = sof ? '0 : (shift ? rows_in_q + 1'b1 : rows_in_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      skid_q       <= '0;
      skid_full_q  <= 1'b0;
      rows_in_q    <= '0;
      win_idx_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      skid_q       <= skid_d;
      skid_full_q  <= skid_full_d;
      rows_in_q    <= rows_in_d;
      win_idx_q    <= win_idx_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_top    = s0_q;
  assign win_mid    = s1_q;
  assign win_bot    = s2_q;
  assign win_idx    = win_idx_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cam_row_scheduler.sv
// Directed bench for cam_row_scheduler: full frame, back-pressure, overflow,
// back-to-back accept, abort and out-of-frame rows.
module tb_cam_row_scheduler;
  localparam int ROW_W = 208;
  localparam int ROWS  = 34;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst, sof, row_valid, pe_ready;
  logic [ROW_W-1:0] row_data;
  logic             win_valid, frame_done, overflow, busy;
  logic [ROW_W-1:0] win_top, win_mid, win_bot;
  logic [IDX_W-1:0] win_idx;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [ROW_W-1:0] ones, fe_row, zero_row;

  cam_row_scheduler #(.ROW_W(ROW_W), .ROWS(ROWS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .sof(sof), .row_valid(row_valid), .row_data(row_data),
    .pe_ready(pe_ready), .win_valid(win_valid), .win_top(win_top), .win_mid(win_mid),
    .win_bot(win_bot), .win_idx(win_idx), .frame_done(frame_done),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  function automatic logic [ROW_W-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i + 16);
    return {26{b}};
  endfunction

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic rv, input logic [ROW_W-1:0] d, input logic pr, input logic sf);
    row_valid = rv; row_data = d; pe_ready = pr; sof = sf;
    @(posedge clk); #1;
    row_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sof = 1'b0; row_valid = 1'b0; pe_ready = 1'b0; row_data = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({win_valid, frame_done, overflow, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {win_valid, frame_done, overflow, busy}); end
    checks++; if (win_idx !== '0 || win_top !== '0 || win_mid !== '0 || win_bot !== '0) begin
      errors++; $display("FAIL reset_window idx=%0d want 0 and zero rows", win_idx); end
  endtask

  task automatic test_idle_row;
    step(1'b1, ones, 1'b1, 1'b0);
    checks++; if ({win_valid, overflow, busy} !== 3'b000) begin
      errors++; $display("FAIL idle_row got %b want 000", {win_valid, overflow, busy}); end
  endtask

  task automatic test_full_frame;
    int fd0;
    fd0 = fd_cnt;
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sof_busy got %b want 1", busy); end
    for (int k = 0; k < ROWS; k++) begin
      step(1'b1, (k == 0) ? fe_row : ones, 1'b1, 1'b0);
      if (k < 2) begin
        checks++; if (win_valid !== 1'b0) begin
          errors++; $display("FAIL fill_valid row %0d got %b want 0", k, win_valid); end
      end else begin
        checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(k - 1) || win_bot !== ones) begin
          errors++; $display("FAIL frame_win row %0d valid=%b idx=%0d want 1 idx=%0d", k, win_valid, win_idx, k - 1); end
      end
      if (k == 2) begin
        checks++; if (win_top !== fe_row || win_mid !== ones) begin
          errors++; $display("FAIL first_win_top got %h want %h", win_top[7:0], fe_row[7:0]); end
      end
    end
    // A 35th row while the last window is held must be discarded quietly.
    step(1'b1, fe_row, 1'b0, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(32) || win_bot !== ones || overflow !== 1'b0) begin
      errors++; $display("FAIL extra_row valid=%b idx=%0d ovf=%b want 1 32 0", win_valid, win_idx, overflow); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({frame_done, busy, win_valid} !== 3'b110) begin
      errors++; $display("FAIL frame_done_pulse got %b want 110", {frame_done, busy, win_valid}); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({frame_done, busy, overflow, win_valid} !== 4'b0000) begin
      errors++; $display("FAIL frame_end got %b want 0000", {frame_done, busy, overflow, win_valid}); end
    checks++; if (fd_cnt !== fd0 + 1) begin
      errors++; $display("FAIL frame_done_count got %0d want %0d", fd_cnt - fd0, 1); end
  endtask

  task automatic test_backpressure;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, pat(k), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, pat(3), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(1) || win_top !== pat(0) ||
                  win_mid !== pat(1) || win_bot !== pat(2) || overflow !== 1'b0) begin
      errors++; $display("FAIL bp_hold valid=%b idx=%0d ovf=%b want 1 1 0", win_valid, win_idx, overflow); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (win_valid !== 1'b0) begin
      errors++; $display("FAIL bp_accept valid=%b want 0", win_valid); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(2) || win_mid !== pat(2) || win_bot !== pat(3)) begin
      errors++; $display("FAIL bp_skid_win valid=%b idx=%0d want 1 2", win_valid, win_idx); end
  endtask

  task automatic test_overflow;
    step(1'b1, pat(4), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_skid got %b want 0", overflow); end
    step(1'b1, pat(5), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop got %b want 1", overflow); end
    step(1'b1, pat(6), 1'b0, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(2) || win_bot !== pat(3)) begin
      errors++; $display("FAIL ovf_hold valid=%b idx=%0d want 1 2", win_valid, win_idx); end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(3) || win_bot !== pat(4) || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_promote valid=%b idx=%0d ovf=%b want 1 3 1", win_valid, win_idx, overflow); end
  endtask

  task automatic test_back_to_back;
    step(1'b1, pat(7), 1'b1, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(4) || win_mid !== pat(4) || win_bot !== pat(7)) begin
      errors++; $display("FAIL b2b_first valid=%b idx=%0d want 1 4", win_valid, win_idx); end
    step(1'b1, pat(8), 1'b1, 1'b0);
    checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(5) || win_top !== pat(4) || win_bot !== pat(8)) begin
      errors++; $display("FAIL b2b_second valid=%b idx=%0d want 1 5", win_valid, win_idx); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if ({overflow, win_valid, busy, frame_done} !== 4'b0010) begin
      errors++; $display("FAIL sof_clear got %b want 0010", {overflow, win_valid, busy, frame_done}); end
  endtask

  task automatic test_abort;
    int fd0;
    fd0 = fd_cnt;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, pat(k + 20), 1'b1, 1'b0);
    step(1'b1, pat(99), 1'b1, 1'b1);
    checks++; if ({win_valid, busy, frame_done} !== 3'b010) begin
      errors++; $display("FAIL abort_sof got %b want 010", {win_valid, busy, frame_done}); end
    for (int k = 0; k < ROWS; k++) begin
      step(1'b1, zero_row, 1'b1, 1'b0);
      if (k >= 2) begin
        checks++; if (win_valid !== 1'b1 || win_idx !== IDX_W'(k - 1) || win_top !== zero_row ||
                      win_mid !== zero_row || win_bot !== zero_row) begin
          errors++; $display("FAIL abort_win row %0d valid=%b idx=%0d want 1 %0d", k, win_valid, win_idx, k - 1); end
      end
    end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (frame_done !== 1'b1) begin
      errors++; $display("FAIL abort_done got %b want 1", frame_done); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (fd_cnt !== fd0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_done_count got %0d busy=%b want 1 0", fd_cnt - fd0, busy); end
  endtask

  initial begin
    ones     = '1;
    fe_row   = {26{8'hFE}};
    zero_row = '0;
    test_reset;
    test_idle_row;
    test_full_frame;
    test_backpressure;
    test_overflow;
    test_back_to_back;
    test_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/cam_row_scheduler.md
# cam_row_scheduler

Frame scheduler between the camera UART receiver and the PE array. Takes complete 208-bit camera rows and start-of-frame pulses, and keeps a 3-row sliding window of the frame. It issues one window per interior row to the PE array over a valid/ready handshake, and absorbs short PE back-pressure with a one-row skid register. It reports frame completion and row loss.

## Interface
Parameters:
- ROW_W, 208, bits per camera row (26 UART bytes)
- ROWS, 34, rows per frame (minimum 3)
- IDX_W, 6, width of the row index; must satisfy 2^IDX_W > ROWS

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous reset, active-high
- sof  in  1  one-cycle pulse; the 0x5A 0x5A frame header has been received
- row_valid  in  1  one-cycle pulse; row_data holds a complete row
- row_data  in  ROW_W  row payload, sampled when row_valid=1
- pe_ready  in  1  PE array accepts the current window this cycle
- win_valid  out  1  window outputs are valid
- win_top  out  ROW_W  row (c-1)
- win_mid  out  ROW_W  row c
- win_bot  out  ROW_W  row c+1
- win_idx  out  IDX_W  center row index c, range 1..ROWS-2
- frame_done  out  1  one-cycle pulse; the last window of the frame was accepted
- overflow  out  1  sticky flag; a row was dropped
- busy  out  1  a frame is in progress (any state other than IDLE)

## Operation
- The state machine has three states: IDLE, FILL and RUN.
- Row register bank:
  - Shift register s0/s1/s2 (s2 newest) drives win_top/win_mid/win_bot.
  - rows_in counts rows accepted this frame, range 0..ROWS.
  - skid holds one row, with a skid_full flag.
- Row acceptance: a row is accepted when row_valid=1 and state is not IDLE. On acceptance: s0<=s1, s1<=s2, s2<=row_data, and rows_in increments.
- IDLE:
  - row_valid is ignored and does not set overflow.
  - sof moves to FILL, clears rows_in, skid_full and overflow.
- FILL:
  - Rows are accepted.
  - When the third row is accepted, move to RUN and raise win_valid.
  - win_idx<=1.
- RUN, window pending (win_valid=1):
  - pe_ready=1 accepts the window and win_valid drops.
  - A row arriving while a window is pending goes to skid if skid_full=0.
  - If skid_full=1, the row is dropped and overflow<=1.
  - A row arriving in the same cycle that pe_ready accepts the window is shifted in directly, producing the next window with no gap.
- RUN, no window pending (win_valid=0):
  - If skid_full=1, shift the skid row in, clear skid_full, raise win_valid, and increment win_idx.
  - Otherwise, the next row_valid is shifted in directly, with the same effect.
- Frame end:
  - The frame ends when rows_in=ROWS and the window with win_idx=ROWS-2 is accepted.
  - At that point: frame_done=1 for one cycle, then go to IDLE, with win_valid=0 and busy=0.
  - Rows beyond ROWS in a frame are discarded, and overflow is not set.
- sof in FILL or RUN aborts the current frame. In that cycle:
  - clear rows_in, skid_full, win_valid and overflow;
  - set state to FILL;
  - do not pulse frame_done;
  - discard a row_valid arriving in the same cycle;
  - pe_ready in that cycle has no effect.
- Window outputs hold stable while win_valid=1 && pe_ready=0.
- win_idx equals rows_in-2 for the window currently held.
- Outputs when win_valid=0 are don't-care, except win_valid itself.

## Timing
- Reset (rst=1 at a clk edge), the values on the following cycle:
  - state=IDLE
  - win_valid=0, frame_done=0, overflow=0, busy=0
  - win_top/win_mid/win_bot=0, win_idx=0
  - rows_in=0, skid_full=0
- Reset applied mid-frame discards everything with no frame_done.
- Latency:
  - row_valid at edge t completing a window gives win_valid=1 after edge t.
  - A skid row is promoted at the edge following window acceptance, so win_valid returns one cycle after the accepting cycle.
- Throughput: with pe_ready tied to 1, there is one window per row_valid. That is ROWS-2=32 windows per frame.
- frame_done is asserted the cycle after the final accepting edge and lasts exactly one cycle.
- busy=1 from the cycle after sof until the cycle frame_done is asserted, inclusive.

## Test plan
- Reset, then sof, then 34 rows with row_data={26{8'hFE}} for row 0 and all-ones for rows 1..33, with pe_ready=1.
  - Required: 32 windows with win_idx=1..32.
  - The first window has win_top={26{8'hFE}}.
  - frame_done pulses once, then busy=0 and overflow=0.
- Back-pressure: pe_ready=0 for two row periods after the first window.
  - Required: the window is held stable, row 3 is in skid, and overflow=0.
  - Releasing pe_ready gives the idx=2 window one cycle after acceptance.
- Overflow: pe_ready=0 while 3 further rows arrive.
  - Required: the first row goes to skid, the next two are dropped, and overflow=1.
  - overflow stays set until the next sof.
- Abort: sof after 10 rows, then a full all-zero frame.
  - Required: no frame_done for the aborted frame.
  - The new frame yields 32 all-zero windows with idx 1..32, then frame_done.
- Simultaneous: pe_ready=1 in the same cycle as row_valid.
  - Required: the next window appears the following cycle, with win_idx incremented by 1 and no skid use.
- row_valid in IDLE and a 35th row in a frame:
  - Required: both ignored, overflow=0, and no window change.
